char_hit_detector: RTL
======================

// Module: char_hit_detector
// PURPOSE
//  Upstream of the game FSM: turns per-pixel overlap of character and bubble drawing requests
//  into one frame-aligned charHit pulse. Generates the frame-based 'counter' tick that paces the
//  life-lost and return-to-game states, and provides a post-respawn invulnerability window.
// PARAMETERS
//  DELAY_FRAMES  60  frames between consecutive counter ticks while character is frozen (>=1)
//  GRACE_FRAMES  30  frames of collision immunity after charStart rises (>=1)
//  CNT_W         8   frame counter width; must hold max(DELAY_FRAMES,GRACE_FRAMES)
// PORTS
//  clk                  in   1  system clock
//  reset                in   1  async active-high reset
//  startOfFrame         in   1  1-cycle pulse at start of each VGA frame
//  charDrawingRequest   in   1  character pixel active this cycle
//  bubbleDrawingRequest in   1  any bubble pixel active this cycle
//  charStart            in   1  from game FSM: 1 = character live/movable
//  charHit              out  1  1-cycle pulse: collision confirmed for last frame
//  counter              out  1  1-cycle pulse: DELAY_FRAMES elapsed while frozen
//  invulnerable         out  1  1 while in GRACE (char flashing)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-count): state=GRACE, frameCnt=0, hitFlag=0; all outputs 0
//    except invulnerable=1. charHit/counter are registered; no pulse in the cycle after reset.
//  - collide = charDrawingRequest & bubbleDrawingRequest. hitFlag is sticky within a frame.
//  - At startOfFrame, frameDone = hitFlag | collide (same-cycle collision counts for the ending
//    frame); hitFlag cleared to 0 that cycle; frameCnt advances only on startOfFrame.
//  - States:
//    ARMED : hitFlag accumulates collide. On startOfFrame: if frameDone & charStart ->
//            charHit=1 next cycle, frameCnt=0, -> FROZEN. If charStart=0 on any cycle -> FROZEN
//            (no charHit).
//    FROZEN: collisions ignored, hitFlag held 0. Each startOfFrame: if frameCnt==DELAY_FRAMES-1
//            -> counter=1 next cycle, frameCnt=0; else frameCnt+1. Ticks repeat while frozen.
//            charStart rising (0->1, registered) -> GRACE, frameCnt=0; takes priority over a tick
//            in the same cycle (tick suppressed).
//    GRACE : collisions ignored; invulnerable=1. Each startOfFrame: frameCnt+1; at
//            frameCnt==GRACE_FRAMES-1 -> ARMED, frameCnt=0, hitFlag=0. charStart falling -> FROZEN.
//  - Latency: charHit asserts 1 clk after the startOfFrame that closes the colliding frame.
//  - At most one charHit per ARMED entry; charHit and counter never high in same cycle.
//  - frameCnt never wraps: compared for equality, cleared on state change.
// STRUCTURE
//  - hit_pkg: typedef enum logic[1:0] {ARMED, FROZEN, GRACE} hit_st_t; default constants
//    DELAY_FRAMES_DEF, GRACE_FRAMES_DEF.
//  - Sub-module frame_tick_counter (CNT_W, clear, advance on startOfFrame, terminal-value
//    compare output) shared by FROZEN and GRACE; one FSM always_ff + always_comb in top.
// TESTING
//  1 Reset, charStart=1, 30 frames no collide -> invulnerable drops after frame 30, no pulses.
//  2 ARMED, collide for 3 clks mid-frame -> exactly one charHit 1 clk after next startOfFrame.
//  3 Collide only in the startOfFrame cycle -> charHit next cycle; following frame no charHit.
//  4 After hit, charStart=0 for 130 frames, DELAY_FRAMES=60 -> counter pulses at frames 60,120.
//  5 charStart rises in same cycle as 60th frame -> no counter, GRACE entered, collide ignored.
//  6 Assert reset mid-FROZEN (frameCnt=40) -> outputs 0, invulnerable=1, GRACE restarts at 0.

Source files
------------

// File: rtl/hit_pkg.sv
// Shared types and default frame counts for the character collision detector.
package hit_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        FROZEN = 2'd1,
        GRACE  = 2'd2
    } hit_st_t;

    localparam int unsigned DELAY_FRAMES_DEF = 60;
    localparam int unsigned GRACE_FRAMES_DEF = 30;
    localparam int unsigned CNT_W_DEF        = 8;

endpackage

// File: rtl/frame_tick_counter.sv
// Frame counter that advances on frame starts and flags when it sits on a terminal value.
module frame_tick_counter
    import hit_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_at_term_c
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over advance so a state change always restarts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_advance) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_at_term_c = (r_cnt == i_term);

endmodule

// File: rtl/char_hit_detector.sv
// Turns per-pixel character/bubble overlap into a frame-aligned hit pulse, paces the
// frozen period with counter ticks and provides a post-respawn invulnerability window.
module char_hit_detector
    import hit_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DELAY_FRAMES_DEF,
    parameter int unsigned GRACE_FRAMES = GRACE_FRAMES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic charDrawingRequest,
    input  logic bubbleDrawingRequest,
    input  logic charStart,
    output logic charHit,
    output logic counter,
    output logic invulnerable
);

    localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] GRACE_TERM = CNT_W'(GRACE_FRAMES - 1);

    hit_st_t          r_state;
    hit_st_t          w_state_nxt;
    logic             r_hit_flag;
    logic             w_hit_flag_nxt;
    logic             r_char_start_q;
    logic             w_collide;
    logic             w_frame_done;
    logic             w_cs_rise;
    logic             w_cs_fall;
    logic             w_char_hit_nxt;
    logic             w_counter_nxt;
    logic             w_cnt_clear;
    logic             w_cnt_adv;
    logic             w_at_term;
    logic [CNT_W-1:0] w_term;

    assign w_collide    = charDrawingRequest & bubbleDrawingRequest;
    assign w_frame_done = r_hit_flag | w_collide;
    assign w_cs_rise    = charStart & ~r_char_start_q;
    assign w_cs_fall    = ~charStart & r_char_start_q;

    frame_tick_counter #(
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_cnt_clear),
        .i_advance   (w_cnt_adv),
        .i_term      (w_term),
        .o_at_term_c (w_at_term)
    );

    // Next-state, sticky hit flag and next pulse values.
    always_comb begin
        w_state_nxt    = r_state;
        w_hit_flag_nxt = 1'b0;
        w_char_hit_nxt = 1'b0;
        w_counter_nxt  = 1'b0;
        w_cnt_clear    = 1'b0;
        w_cnt_adv      = 1'b0;
        w_term         = GRACE_TERM;
        case (r_state)
            ARMED: begin
                if (!charStart) begin
                    w_state_nxt = FROZEN;
                    w_cnt_clear = 1'b1;
                end else if (startOfFrame) begin
                    if (w_frame_done) begin
                        w_char_hit_nxt = 1'b1;
                        w_state_nxt    = FROZEN;
                        w_cnt_clear    = 1'b1;
                    end
                end else begin
                    w_hit_flag_nxt = w_frame_done;
                end
            end
            FROZEN: begin
                w_term = DELAY_TERM;
                // A respawn request beats a tick landing on the same cycle.
                if (w_cs_rise) begin
                    w_state_nxt = GRACE;
                    w_cnt_clear = 1'b1;
                end else if (startOfFrame) begin
                    if (w_at_term) begin
                        w_counter_nxt = 1'b1;
                        w_cnt_clear   = 1'b1;
                    end else begin
                        w_cnt_adv = 1'b1;
                    end
                end
            end
            GRACE: begin
                if (w_cs_fall) begin
                    w_state_nxt = FROZEN;
                    w_cnt_clear = 1'b1;
                end else if (startOfFrame) begin
                    if (w_at_term) begin
                        w_state_nxt = ARMED;
                        w_cnt_clear = 1'b1;
                    end else begin
                        w_cnt_adv = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = GRACE;
                w_cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= GRACE;
            r_hit_flag     <= 1'b0;
            r_char_start_q <= 1'b0;
            charHit        <= 1'b0;
            counter        <= 1'b0;
            invulnerable   <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_hit_flag     <= w_hit_flag_nxt;
            r_char_start_q <= charStart;
            charHit        <= w_char_hit_nxt;
            counter        <= w_counter_nxt;
            invulnerable   <= (w_state_nxt == GRACE);
        end
    end

endmodule
